sipo: RTL and testbench

SIPO -- requirements
Module: sipo

---
 rtl/sipo.sv | 52 +++++
 tb/tb_sipo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo.sv
// Serial-in parallel-out shift register: streams si into a WIDTH-bit word,
// strobes pvalid for one cycle per completed word and echoes si on so after WIDTH edges.
module sipo #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  output logic             so,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid
);

  localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr_next_c;
  logic             word_done_c;

  assign sr_next_c   = {sr[WIDTH-2:0], si};
  assign word_done_c = (cnt == CNT_LAST);

  // Shift register; si passes through unsanitised so X/Z propagate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr <= sr_next_c;
    end
  end

  // Bit counter and word capture; the completing edge loads the post-shift value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      pout   <= '0;
      pvalid <= 1'b0;
    end else if (word_done_c) begin
      cnt    <= '0;
      pout   <= sr_next_c;
      pvalid <= 1'b1;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      pvalid <= 1'b0;
    end
  end

  assign so = sr[WIDTH-1];

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo (WIDTH=4): expected words are queued as bits are
// driven and popped when pvalid fires; fixed vectors cover the reset scenarios.
module tb_sipo;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         si;
  logic         so;
  logic [W-1:0] pout;
  logic         pvalid;

  int n_vec;
  int n_err;

  // Bench-side model state
  int unsigned  nbits;
  logic [W-1:0] acc;
  logic         hist[$];
  logic [W-1:0] exp_q[$];
  logic         exp_pv;
  logic         exp_so;
  logic [W-1:0] exp_pout;
  logic [W-1:0] got_word;

  sipo #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .si     (si),
    .so     (so),
    .pout   (pout),
    .pvalid (pvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    nbits = 0;
    acc   = '0;
    hist.delete();
    for (int i = 0; i < int'(W) - 1; i++) hist.push_back(1'b0);
    exp_q.delete();
    exp_pv   = 1'b0;
    exp_so   = 1'b0;
    exp_pout = '0;
  endtask

  // Drive one bit across one rising edge and advance the expectation model.
  task automatic shift_bit(input logic b);
    si = b;
    @(posedge clk);
    #1;
    acc = {acc[W-2:0], b};
    nbits++;
    hist.push_back(b);
    exp_so = hist.pop_front();
    exp_pv = 1'b0;
    if (nbits == W) begin
      exp_q.push_back(acc);
      nbits  = 0;
      exp_pv = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    si  = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) begin
      si = ~si;
      @(posedge clk);
      #1;
      n_vec++;
      if ({so, pout, pvalid} !== '0) begin
        n_err++;
        $display("FAIL reset_hold edge %0d: so=%b pout=%b pvalid=%b, required all 0", i, so, pout, pvalid);
      end
    end
    model_clear();
    rst = 1'b1;
  endtask

  // Word 1010 then zeros: checks latency of so, the first strobe and a zero word.
  task automatic test_first_word();
    logic [7:0] bits;
    logic [7:0] so_ref;
    bits   = 8'b1010_0000;
    so_ref = 8'b0001_0100;
    for (int i = 0; i < 8; i++) begin
      shift_bit(bits[7-i]);
      n_vec++;
      if (so !== so_ref[7-i] || so !== exp_so) begin
        n_err++;
        $display("FAIL first_word_so edge %0d: so=%b, required %b", i + 1, so, so_ref[7-i]);
      end
      n_vec++;
      if (pvalid !== exp_pv) begin
        n_err++;
        $display("FAIL first_word_pvalid edge %0d: pvalid=%b, required %b", i + 1, pvalid, exp_pv);
      end
      if (exp_pv) begin
        got_word = exp_q.pop_front();
        exp_pout = got_word;
        n_vec++;
        if (pout !== ((i == 3) ? 4'b1010 : 4'b0000) || pout !== got_word) begin
          n_err++;
          $display("FAIL first_word_pout edge %0d: pout=%b, required %b", i + 1, pout, got_word);
        end
      end else if (i > 3) begin
        n_vec++;
        if (pout !== exp_pout) begin
          n_err++;
          $display("FAIL first_word_hold edge %0d: pout=%b, required %b", i + 1, pout, exp_pout);
        end
      end
    end
  endtask

  // 1100_0011 followed by random back-to-back words, no gap cycles.
  task automatic test_back_to_back();
    logic [7:0] bits;
    int         strobes;
    bits    = 8'b1100_0011;
    strobes = 0;
    for (int i = 0; i < 8 + 16 * int'(W); i++) begin
      shift_bit((i < 8) ? bits[7-i] : 1'($urandom_range(0, 1)));
      n_vec++;
      if (pvalid !== exp_pv || so !== exp_so) begin
        n_err++;
        $display("FAIL stream_ctl edge %0d: pvalid=%b so=%b, required pvalid=%b so=%b", i, pvalid, so, exp_pv, exp_so);
      end
      if (exp_pv) begin
        got_word = exp_q.pop_front();
        exp_pout = got_word;
        strobes++;
        n_vec++;
        if (pout !== got_word) begin
          n_err++;
          $display("FAIL stream_word %0d: pout=%b, required %b", strobes, pout, got_word);
        end
        if (strobes <= 2) begin
          n_vec++;
          if (pout !== ((strobes == 1) ? 4'b1100 : 4'b0011)) begin
            n_err++;
            $display("FAIL stream_fixed %0d: pout=%b, required %b", strobes, pout, (strobes == 1) ? 4'b1100 : 4'b0011);
          end
        end
      end else if (pout !== exp_pout) begin
        n_vec++;
        n_err++;
        $display("FAIL stream_hold edge %0d: pout=%b, required %b", i, pout, exp_pout);
      end
    end
    n_vec++;
    if (strobes != 2 + 16) begin
      n_err++;
      $display("FAIL stream_count: strobes=%0d, required %0d", strobes, 18);
    end
  endtask

  // Reset between edges after 2 bits, then a fresh 1111 word needs 4 full edges.
  task automatic test_mid_reset();
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b0);
    shift_bit(1'b1);
    n_vec++;
    if (pvalid !== 1'b1 || pout !== 4'b1001) begin
      n_err++;
      $display("FAIL mid_reset_pre: pvalid=%b pout=%b, required 1 1001", pvalid, pout);
    end
    shift_bit(1'b1);
    shift_bit(1'b1);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({so, pout, pvalid} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_async: so=%b pout=%b pvalid=%b, required all 0", so, pout, pvalid);
    end
    #2;
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      shift_bit(1'b1);
      n_vec++;
      if (pvalid !== (i == 3) || pout !== ((i == 3) ? 4'b1111 : 4'b0000)) begin
        n_err++;
        $display("FAIL mid_reset_word edge %0d: pvalid=%b pout=%b, required %b %b", i + 1, pvalid, pout, (i == 3), (i == 3) ? 4'b1111 : 4'b0000);
      end
    end
    exp_q.delete();
    exp_pout = 4'b1111;
  endtask

  // Reset held across what would be the completing edge: no strobe, pout cleared.
  task automatic test_reset_on_complete();
    shift_bit(1'b0);
    shift_bit(1'b1);
    shift_bit(1'b1);
    si  = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (pvalid !== 1'b0 || pout !== 4'b0000 || so !== 1'b0) begin
      n_err++;
      $display("FAIL reset_on_complete: pvalid=%b pout=%b so=%b, required 0 0000 0", pvalid, pout, so);
    end
    #2;
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      shift_bit(1'($urandom_range(0, 1)));
      n_vec++;
      if (pvalid !== exp_pv || so !== exp_so) begin
        n_err++;
        $display("FAIL after_reset edge %0d: pvalid=%b so=%b, required %b %b", i + 1, pvalid, so, exp_pv, exp_so);
      end
    end
    got_word = exp_q.pop_front();
    n_vec++;
    if (pout !== got_word) begin
      n_err++;
      $display("FAIL after_reset_word: pout=%b, required %b", pout, got_word);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    si    = 1'b0;
    model_clear();
    test_reset();
    test_first_word();
    test_back_to_back();
    test_mid_reset();
    test_reset_on_complete();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
